// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio constants and the playback state type
// Contents:
//   AUDIO_CLK_DIV  : system clocks per PDM bit (shared with the capture block)
//   AUDIO_OSR      : PDM bits per PCM sample
//   AUDIO_SAMPLE_W : PCM sample width, two's complement
//   audio_state_e  : playback state machine encoding {IDLE, RUN}
package audio_pkg;

  localparam int AUDIO_CLK_DIV  = 32;
  localparam int AUDIO_OSR      = 64;
  localparam int AUDIO_SAMPLE_W = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } audio_state_e;

endpackage

// File: rtl/pcm_fifo.sv
// rtl/pcm_fifo.sv - synchronous sample FIFO with flush
// Ports:
//   clock    in   system clock
//   reset    in   synchronous, active-high
//   flush_i  in   empties the FIFO on the next edge; wins over push and pop
//   push_i   in   write data_i (ignored when full)
//   data_i   in   sample to write
//   pop_i    in   drop the head entry (ignored when empty)
//   data_o   out  head entry
//   full_o   out  FIFO holds DEPTH entries
//   empty_o  out  FIFO holds no entries
//   level_o  out  current occupancy, 0..DEPTH
module pcm_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (level_o == FULL_LVL);
  assign empty_o = (level_o == '0);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A full FIFO refuses a push even when the same cycle pops.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/pdm_audio_out.sv
// rtl/pdm_audio_out.sv - PCM playback to 1-bit PDM via FIFO and first-order sigma-delta
// Ports:
//   clock       in   100 MHz system clock
//   reset       in   synchronous, active-high
//   enable      in   playback enable; low = idle and flush
//   pcm_data    in   signed PCM sample
//   pcm_valid   in   pcm_data valid
//   pcm_ready   out  FIFO can accept a sample (RUN and not full)
//   pdm_out     out  registered PDM bit to the amplifier
//   amp_en      out  amplifier enable, high while in RUN
//   underflow   out  one-cycle pulse when a sample boundary finds the FIFO empty
//   fifo_level  out  current FIFO occupancy
module pdm_audio_out
  import audio_pkg::*;
#(
  parameter int CLK_DIV    = AUDIO_CLK_DIV,
  parameter int OSR        = AUDIO_OSR,
  parameter int SAMPLE_W   = AUDIO_SAMPLE_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [SAMPLE_W-1:0]           pcm_data,
  input  logic                          pcm_valid,
  output logic                          pcm_ready,
  output logic                          pdm_out,
  output logic                          amp_en,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int OSR_W = $clog2(OSR);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [OSR_W-1:0] OSR_LAST = OSR_W'(OSR - 1);

  audio_state_e        state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [OSR_W-1:0]    osr_cnt_q, osr_cnt_d;
  logic [SAMPLE_W-1:0] acc_q, acc_d;
  logic [SAMPLE_W-1:0] cur_sample_q, cur_sample_d;
  logic                pdm_q, pdm_d;

  logic                run_w;
  logic                tick_w;
  logic                boundary_w;
  logic [SAMPLE_W-1:0] offset_w;
  logic [SAMPLE_W:0]   sum_w;

  logic                fifo_flush;
  logic                fifo_push;
  logic                fifo_pop;
  logic [SAMPLE_W-1:0] fifo_head;
  logic                fifo_full;
  logic                fifo_empty;

  // Both transitions simply follow enable, so IDLE->RUN->IDLE without a tick is fine.
  assign state_d = enable ? RUN : IDLE;

  // The modulator only advances while RUN is held; the clock that drops enable
  // already loads the idle values so outputs are quiet one edge later.
  assign run_w      = (state_q == RUN) && enable && !reset;
  assign tick_w     = (div_cnt_q == DIV_LAST);
  assign boundary_w = tick_w && (osr_cnt_q == OSR_LAST);

  // Offset-binary view of the sample; the carry out of acc + u is the PDM bit.
  assign offset_w = {~cur_sample_q[SAMPLE_W-1], cur_sample_q[SAMPLE_W-2:0]};
  assign sum_w    = {1'b0, acc_q} + {1'b0, offset_w};

  assign fifo_flush = (state_d == IDLE);
  assign fifo_push  = pcm_valid && pcm_ready;
  assign fifo_pop   = run_w && boundary_w;

  assign pcm_ready = (state_q == RUN) && !fifo_full;
  assign amp_en    = (state_q == RUN);
  assign pdm_out   = pdm_q;
  assign underflow = run_w && boundary_w && fifo_empty;

  always_comb begin
    div_cnt_d    = div_cnt_q;
    osr_cnt_d    = osr_cnt_q;
    acc_d        = acc_q;
    cur_sample_d = cur_sample_q;
    pdm_d        = pdm_q;
    if (!run_w) begin
      // osr_cnt parks at OSR-1 so the very first tick is a sample boundary.
      div_cnt_d    = '0;
      osr_cnt_d    = OSR_LAST;
      acc_d        = '0;
      cur_sample_d = '0;
      pdm_d        = 1'b0;
    end else begin
      div_cnt_d = tick_w ? '0 : div_cnt_q + 1'b1;
      if (tick_w) begin
        // The boundary bit still uses the old sample; the new one takes effect next tick.
        acc_d     = sum_w[SAMPLE_W-1:0];
        pdm_d     = sum_w[SAMPLE_W];
        osr_cnt_d = (osr_cnt_q == OSR_LAST) ? '0 : osr_cnt_q + 1'b1;
        if (boundary_w) begin
          cur_sample_d = fifo_empty ? '0 : fifo_head;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      div_cnt_q    <= '0;
      osr_cnt_q    <= OSR_LAST;
      acc_q        <= '0;
      cur_sample_q <= '0;
      pdm_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      osr_cnt_q    <= osr_cnt_d;
      acc_q        <= acc_d;
      cur_sample_q <= cur_sample_d;
      pdm_q        <= pdm_d;
    end
  end

  pcm_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .data_i  (pcm_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

endmodule

// File: tb/tb_pdm_audio_out.sv
// tb/tb_pdm_audio_out.sv - self-checking bench for pdm_audio_out
module tb_pdm_audio_out;

  localparam int CLK_DIV = 4;
  localparam int OSR     = 16;
  localparam int W       = 16;
  localparam int DEPTH   = 4;
  localparam int LW      = $clog2(DEPTH) + 1;
  localparam int SPS     = CLK_DIV * OSR;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [W-1:0]  pcm_data;
  logic          pcm_valid;
  logic          pcm_ready;
  logic          pdm_out;
  logic          amp_en;
  logic          underflow;
  logic [LW-1:0] fifo_level;

  always #5 clock = ~clock;

  pdm_audio_out #(
    .CLK_DIV    (CLK_DIV),
    .OSR        (OSR),
    .SAMPLE_W   (W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .pcm_data   (pcm_data),
    .pcm_valid  (pcm_valid),
    .pcm_ready  (pcm_ready),
    .pdm_out    (pdm_out),
    .amp_en     (amp_en),
    .underflow  (underflow),
    .fifo_level (fifo_level)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: a sample queue, the clock count since entering RUN, and
  // an integer accumulator fed with sample + 2^(W-1).
  bit           m_run;
  int           m_clk;
  int           m_acc;
  logic [W-1:0] m_cur;
  logic         m_pdm;
  logic [W-1:0] m_q[$];

  int           feed_mode;
  logic [W-1:0] feed_value;
  int           feed_rate;

  logic last_pdm, last_amp, last_ready, last_uf;
  int   last_lvl;
  int   acc_ones, acc_ready, acc_uf, acc_maxlvl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_tick();
    return m_run && ((m_clk % CLK_DIV) == CLK_DIV - 1);
  endfunction

  function automatic bit m_boundary();
    return m_tick() && (((m_clk / CLK_DIV) % OSR) == 0);
  endfunction

  task automatic model_clear();
    m_clk = 0;
    m_acc = 0;
    m_cur = '0;
    m_pdm = 1'b0;
    m_q.delete();
  endtask

  task automatic model_update();
    bit push_ok;
    int u;
    int s;
    if (reset) begin
      m_run = 0;
      model_clear();
    end else if (!m_run) begin
      if (enable) begin
        m_run = 1;
        model_clear();
      end
    end else if (!enable) begin
      m_run = 0;
      model_clear();
    end else begin
      push_ok = pcm_valid && (m_q.size() < DEPTH);
      if (m_tick()) begin
        u = int'($signed(m_cur)) + (1 << (W - 1));
        s = m_acc + u;
        m_pdm = (s >= (1 << W));
        m_acc = s % (1 << W);
        if (m_boundary()) begin
          if (m_q.size() > 0) m_cur = m_q.pop_front();
          else m_cur = '0;
        end
      end
      if (push_ok) m_q.push_back(pcm_data);
      m_clk++;
    end
  endtask

  // One clock: drive stimulus at the falling edge, compare mid-cycle, then
  // advance the model on the rising edge.
  task automatic step();
    bit exp_uf;
    if (feed_mode == 1) begin
      pcm_valid = 1'b1;
      pcm_data  = feed_value;
    end else if (feed_mode == 2) begin
      pcm_valid = ($urandom_range(0, 99) < feed_rate);
      pcm_data  = W'($urandom);
    end else begin
      pcm_valid = 1'b0;
    end
    #1;
    exp_uf = m_boundary() && enable && !reset && (m_q.size() == 0);
    chk("pdm_out",    32'(pdm_out),    32'(m_pdm));
    chk("amp_en",     32'(amp_en),     32'(m_run));
    chk("pcm_ready",  32'(pcm_ready),  32'(m_run && (m_q.size() < DEPTH)));
    chk("underflow",  32'(underflow),  32'(exp_uf));
    chk("fifo_level", 32'(fifo_level), 32'(m_q.size()));
    last_pdm   = pdm_out;
    last_amp   = amp_en;
    last_ready = pcm_ready;
    last_uf    = underflow;
    last_lvl   = int'(fifo_level);
    if (m_tick() && pdm_out) acc_ones++;
    if (pcm_ready) acc_ready++;
    if (underflow) acc_uf++;
    if (int'(fifo_level) > acc_maxlvl) acc_maxlvl = int'(fifo_level);
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic measure(input int n);
    acc_ones = 0; acc_ready = 0; acc_uf = 0; acc_maxlvl = 0;
    run(n);
  endtask

  // Called with enable (and !reset) already set while idle; checks the
  // startup timing of amp_en, the first boundary underflow and the first 1 bit.
  task automatic restart_check(input string tag);
    int first_uf;
    int first_one;
    int uf_cnt;
    bit amp_first;
    step();
    first_uf = -1; first_one = -1; uf_cnt = 0; amp_first = 0;
    for (int i = 0; i < 3 * CLK_DIV; i++) begin
      step();
      if (i == 0) amp_first = last_amp;
      if (last_uf) uf_cnt++;
      if (last_uf && first_uf < 0) first_uf = i;
      if (last_pdm && first_one < 0) first_one = i;
    end
    chk({tag, "_amp_first"}, 32'(amp_first), 32'd1);
    chk({tag, "_first_uf"},  32'(first_uf),  32'(CLK_DIV - 1));
    chk({tag, "_uf_once"},   32'(uf_cnt),    32'd1);
    chk({tag, "_first_one"}, 32'(first_one), 32'(2 * CLK_DIV));
  endtask

  initial begin
    logic [W-1:0] stream_vals [4];
    int ones;
    stream_vals[0] = 16'h0000;
    stream_vals[1] = 16'h4000;
    stream_vals[2] = 16'h8000;
    stream_vals[3] = 16'h7FFF;

    reset = 1'b1; enable = 1'b1; pcm_valid = 1'b0; pcm_data = '0;
    feed_mode = 0; feed_value = '0; feed_rate = 0;
    m_run = 0;
    model_clear();
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);

    // Held in reset with enable high: everything quiet.
    run(3);
    chk("reset_amp",   32'(last_amp),   32'd0);
    chk("reset_ready", 32'(last_ready), 32'd0);
    chk("reset_pdm",   32'(last_pdm),   32'd0);
    chk("reset_level", 32'(last_lvl),   32'd0);

    reset = 1'b0;
    restart_check("post_reset");

    // Constant streams: bits per OSR window follow the offset-binary duty cycle.
    foreach (stream_vals[k]) begin
      feed_mode  = 1;
      feed_value = stream_vals[k];
      run((DEPTH + 2) * SPS);
      measure(SPS);
      ones = acc_ones;
      case (k)
        0: chk("ones_0000", 32'(ones), 32'(OSR / 2));
        1: chk("ones_4000_in_range", 32'((ones >= 3 * OSR / 4 - 1) && (ones <= 3 * OSR / 4 + 1)), 32'd1);
        2: chk("ones_8000", 32'(ones), 32'd0);
        default: begin
          chk("ones_7fff_min", 32'(ones >= OSR - 1), 32'd1);
          chk("full_ready_cycles", 32'(acc_ready), 32'd1);
          chk("full_max_level", 32'(acc_maxlvl), 32'(DEPTH));
        end
      endcase
    end

    // Drain: one single-cycle underflow per boundary, output back to 50% duty.
    feed_mode = 0;
    run((DEPTH + 1) * SPS);
    measure(3 * SPS);
    chk("drain_uf_pulses", 32'(acc_uf),   32'd3);
    chk("drain_ones",      32'(acc_ones), 32'(3 * OSR / 2));

    // Random producer rates: mostly-full then starved.
    feed_mode = 2;
    feed_rate = 4;
    run(6 * SPS);
    feed_rate = 1;
    run(6 * SPS);

    // Reset in the middle of playback, then resume with random data.
    feed_rate = 4;
    run(SPS / 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    run(3 * SPS);

    // Queue exactly DEPTH-1 samples, then drop enable mid-sample.
    feed_mode  = 1;
    feed_value = W'($urandom);
    for (int i = 0; i < 4 * SPS && last_lvl != DEPTH; i++) step();
    chk("fill_to_full", 32'(last_lvl), 32'(DEPTH));
    feed_mode = 0;
    for (int i = 0; i < 2 * SPS && last_lvl != DEPTH - 1; i++) step();
    run(SPS / 4);
    chk("queued_before_drop", 32'(last_lvl), 32'(DEPTH - 1));
    enable = 1'b0;
    step();
    #1;
    chk("drop_level", 32'(fifo_level), 32'd0);
    chk("drop_pdm",   32'(pdm_out),    32'd0);
    chk("drop_amp",   32'(amp_en),     32'd0);
    @(negedge clock);
    run(5);

    enable = 1'b1;
    restart_check("reenable");
    run(SPS);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
